// File: rtl/button_debouncer.sv
// Per-bit synchronizer, stability-count debouncer and sticky press latch for
// the front-panel buttons feeding the memory-mapped I/O block.
module button_debouncer #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_buttons,
  input  logic [WIDTH-1:0] clear_pressed,
  output logic [WIDTH-1:0] buttons,
  output logic [WIDTH-1:0] pressed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise;

  // A bit flips its debounced level only after STABLE_CYCLES mismatching cycles.
  always_comb begin
    accept = '0;
    rise   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != buttons[i]) && (cnt[i] == CNT_LAST);
      rise[i]   = accept[i] && sync2[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      buttons <= '0;
      pressed <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw_buttons;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == buttons[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          buttons[i] <= sync2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
      // A new press wins over a coincident clear so the event is never lost.
      pressed <= rise | (pressed & ~clear_pressed);
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, WIDTH=16.
module tb_button_debouncer;

  localparam int WIDTH = 16;
  localparam int STABLE = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] raw_buttons;
  logic [WIDTH-1:0] clear_pressed;
  logic [WIDTH-1:0] buttons;
  logic [WIDTH-1:0] pressed;

  int vectors;
  int miscompares;

  button_debouncer #(
    .WIDTH(WIDTH),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_buttons(raw_buttons),
    .clear_pressed(clear_pressed),
    .buttons(buttons),
    .pressed(pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    raw_buttons = '0;
    clear_pressed = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw_buttons = 16'hFFFF;
    clear_pressed = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (buttons !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_buttons cycle %0d: got %h expected %h", c, buttons, 16'h0000);
      end
      vectors++;
      if (pressed !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_pressed cycle %0d: got %h expected %h", c, pressed, 16'h0000);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      vectors++;
      if (buttons !== ((e == 6) ? 16'hFFFF : 16'h0000)) begin
        miscompares++;
        $display("FAIL post_reset_buttons edge %0d: got %h expected %h", e, buttons,
                 (e == 6) ? 16'hFFFF : 16'h0000);
      end
      vectors++;
      if (pressed !== ((e == 6) ? 16'hFFFF : 16'h0000)) begin
        miscompares++;
        $display("FAIL post_reset_pressed edge %0d: got %h expected %h", e, pressed,
                 (e == 6) ? 16'hFFFF : 16'h0000);
      end
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    raw_buttons = 16'h0008;
    for (int e = 0; e <= 5; e++) begin
      tick();
      vectors++;
      if (buttons !== ((e == 5) ? 16'h0008 : 16'h0000)) begin
        miscompares++;
        $display("FAIL clean_press_buttons edge k+%0d: got %h expected %h", e, buttons,
                 (e == 5) ? 16'h0008 : 16'h0000);
      end
      vectors++;
      if (pressed !== ((e == 5) ? 16'h0008 : 16'h0000)) begin
        miscompares++;
        $display("FAIL clean_press_pressed edge k+%0d: got %h expected %h", e, pressed,
                 (e == 5) ? 16'h0008 : 16'h0000);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pattern;
    do_reset();
    pattern = 6'b101101;  // applied LSB first: 1,0,1,1,0,1
    for (int c = 0; c < 6; c++) begin
      raw_buttons = {15'b0, pattern[c]};
      tick();
      vectors++;
      if (buttons !== 16'h0000) begin
        miscompares++;
        $display("FAIL bounce_during cycle %0d: got %h expected %h", c, buttons, 16'h0000);
      end
    end
    // The final 1 was set up before the last edge above (edge k).
    for (int e = 1; e <= 5; e++) begin
      tick();
      vectors++;
      if (buttons !== ((e == 5) ? 16'h0001 : 16'h0000)) begin
        miscompares++;
        $display("FAIL bounce_settle edge k+%0d: got %h expected %h", e, buttons,
                 (e == 5) ? 16'h0001 : 16'h0000);
      end
    end
  endtask

  task automatic test_short_glitch();
    do_reset();
    raw_buttons = 16'h0080;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) raw_buttons = 16'h0000;
      tick();
      vectors++;
      if (buttons !== 16'h0000 || pressed !== 16'h0000) begin
        miscompares++;
        $display("FAIL glitch cycle %0d: got buttons %h pressed %h expected 0000 0000",
                 c, buttons, pressed);
      end
    end
  endtask

  task automatic test_clear_race();
    do_reset();
    raw_buttons = 16'h0004;
    repeat (6) tick();
    vectors++;
    if (pressed !== 16'h0004) begin
      miscompares++;
      $display("FAIL clear_setup_pressed: got %h expected %h", pressed, 16'h0004);
    end
    clear_pressed = 16'h0004;
    tick();
    clear_pressed = 16'h0000;
    vectors++;
    if (pressed !== 16'h0000) begin
      miscompares++;
      $display("FAIL clear_pressed_effect: got %h expected %h", pressed, 16'h0000);
    end
    raw_buttons = 16'h0000;
    repeat (6) tick();
    vectors++;
    if (buttons !== 16'h0000 || pressed !== 16'h0000) begin
      miscompares++;
      $display("FAIL clear_release: got buttons %h pressed %h expected 0000 0000", buttons, pressed);
    end
    raw_buttons = 16'h0004;
    repeat (5) tick();
    vectors++;
    if (buttons !== 16'h0000) begin
      miscompares++;
      $display("FAIL race_early_buttons: got %h expected %h", buttons, 16'h0000);
    end
    clear_pressed = 16'h0004;  // coincides with the rise edge k+5
    tick();
    clear_pressed = 16'h0000;
    vectors++;
    if (buttons !== 16'h0004) begin
      miscompares++;
      $display("FAIL race_buttons: got %h expected %h", buttons, 16'h0004);
    end
    vectors++;
    if (pressed !== 16'h0004) begin
      miscompares++;
      $display("FAIL race_set_wins: got %h expected %h", pressed, 16'h0004);
    end
    tick();
    vectors++;
    if (pressed !== 16'h0004) begin
      miscompares++;
      $display("FAIL race_hold: got %h expected %h", pressed, 16'h0004);
    end
  endtask

  task automatic test_release_independence();
    do_reset();
    raw_buttons = 16'h0020;
    repeat (6) tick();
    vectors++;
    if (buttons !== 16'h0020) begin
      miscompares++;
      $display("FAIL indep_press5: got %h expected %h", buttons, 16'h0020);
    end
    clear_pressed = 16'h0020;
    tick();
    clear_pressed = 16'h0000;
    vectors++;
    if (pressed !== 16'h0000) begin
      miscompares++;
      $display("FAIL indep_clear5: got %h expected %h", pressed, 16'h0000);
    end
    // Release bit 5 while bit 6 carries a 3-cycle glitch.
    raw_buttons = 16'h0040;
    for (int e = 0; e <= 8; e++) begin
      if (e == 3) raw_buttons = 16'h0000;
      tick();
      vectors++;
      if (buttons !== ((e >= 5) ? 16'h0000 : 16'h0020)) begin
        miscompares++;
        $display("FAIL indep_release edge k+%0d: got %h expected %h", e, buttons,
                 (e >= 5) ? 16'h0000 : 16'h0020);
      end
      vectors++;
      if (pressed !== 16'h0000) begin
        miscompares++;
        $display("FAIL indep_pressed edge k+%0d: got %h expected %h", e, pressed, 16'h0000);
      end
    end
    raw_buttons = 16'h0040;
    repeat (6) tick();
    vectors++;
    if (buttons !== 16'h0040 || pressed !== 16'h0040) begin
      miscompares++;
      $display("FAIL indep_press6: got buttons %h pressed %h expected 0040 0040", buttons, pressed);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    raw_buttons = '0;
    clear_pressed = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_glitch();
    test_clear_race();
    test_release_independence();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions the raw front-panel button inputs before they reach the memory-mapped I/O block, and drives that block's 16-bit `buttons` input directly. Each bit is synchronized into `clk`, debounced by a per-bit stability counter, and edge-detected. Press events are held in a sticky register until software-driven logic clears them, so short presses are not lost between polls.

## Interface

Parameters:
- `WIDTH`, 16: number of button channels.
- `STABLE_CYCLES`, 50000: consecutive cycles a synchronized input must differ from the debounced level before the level changes.
  - Legal range is ≥1.
  - The default is 1 ms at 50 MHz.
- `CNT_W`, `$clog2(STABLE_CYCLES+1)`: counter width; derived, never overridden.

Ports:
- `clk`, input, 1: the single system clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `raw_buttons`, input, WIDTH: asynchronous, bouncing pad inputs. 1 = pressed.
- `clear_pressed`, input, WIDTH: write-1-to-clear strobe for `pressed`. Sampled each cycle.
- `buttons`, output, WIDTH: debounced level. Connects to the memory-mapped I/O `buttons` input.
- `pressed`, output, WIDTH: sticky rising-edge flags, one per channel.

## Operation

- Each bit i is processed independently by identical logic.
- **Synchronizer:** two flops per bit, `sync1[i] <= raw_buttons[i]` and `sync2[i] <= sync1[i]`. Only `sync2` feeds later logic.
- **Debounce counter:** each bit has a counter `cnt[i]` of width `CNT_W`. Per cycle:
  - If `sync2[i] == buttons[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == STABLE_CYCLES-1`: `buttons[i] <= sync2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i] + 1`.
- The counter therefore never exceeds `STABLE_CYCLES-1`, and it never wraps.
- Any single cycle in which `sync2` matches `buttons` restarts the count. Glitches shorter than `STABLE_CYCLES` cycles never reach `buttons`.
- **Event latch:** `rise[i]` is asserted on the same edge at which `buttons[i]` goes 0→1.
  - Next value of `pressed[i]` = `rise[i] | (pressed[i] & ~clear_pressed[i])`.
  - If set and clear coincide, set wins: the new press stays latched.
  - Release (1→0) never sets `pressed`.
  - Repeated presses before a clear stay at 1. The flag does not count presses.
- **Reset:** while `rst`=1 at a rising edge, the following all go to 0:
  - `sync1`, `sync2`, `cnt`, `buttons` (all buttons reported released),
  - `pressed`.
- A bounce sequence interrupted by reset restarts from scratch after reset is released.
- A button that is physically held through reset is reported pressed `STABLE_CYCLES+2` edges after `rst` deasserts. It also sets `pressed`.

## Timing

- Both outputs are registered. There is no combinational path from any input to any output.
- Latency is measured from a clean `raw_buttons` change that is set up before edge k:
  - `sync2` shows the new value after edge k+1.
  - `buttons` updates at edge k+1+`STABLE_CYCLES`.
  - Total latency is `STABLE_CYCLES`+2 edges.
- `pressed` rises on the same edge as `buttons`.
- `clear_pressed` takes effect on the next edge. Latency is 1 cycle.
- Minimum accepted pulse width at `sync2` is `STABLE_CYCLES` cycles. Shorter pulses are filtered out.
- After reset, outputs are valid and stable (all 0) from the first edge at which `rst`=1.

## Test plan

All scenarios use `STABLE_CYCLES`=4 and `WIDTH`=16.

1. **Reset:** drive `rst`=1 for 2 cycles with `raw_buttons`=16'hFFFF → `buttons`=0 and `pressed`=0 during reset. After release, `buttons`=16'hFFFF and `pressed`=16'hFFFF exactly 6 edges later.
2. **Clean press:** `raw_buttons[3]` goes 0→1 before edge k and is held → `buttons`=16'h0008 and `pressed`=16'h0008 first seen after edge k+5, not earlier.
3. **Bounce rejection:** `raw_buttons[0]` toggles 1,0,1,1,0,1 (one value per cycle), then holds 1 → no change during the bounce. `buttons[0]`=1 exactly 6 edges after the final 0→1 transition.
4. **Short glitch:** `raw_buttons[7]` held high for 3 cycles, then low → `buttons` and `pressed` stay 0 throughout.
5. **Clear vs set race:**
   - With `pressed[2]`=1, pulse `clear_pressed`=16'h0004 for 1 cycle → `pressed[2]`=0 on the next edge.
   - Repeat with the clear pulse on the same edge as a new `buttons[2]` rise → `pressed[2]` stays 1.
6. **Release and independence:**
   - Press bit 5; clear `pressed`; release bit 5 → `buttons[5]` falls 6 edges after the release and `pressed` stays 0.
   - Simultaneously bounce bit 6 → bit 6 filtering is unaffected by bit 5.
